// File: rtl/if_row_packer_pkg.sv
// Shared constants for the IF row packer: lane layout of a tagged element and
// the packer state encoding, also used by the datapath unpacker.
package if_row_packer_pkg;

  localparam int FLAG_W  = 2;
  localparam int EOR_OFS = 0;
  localparam int SOR_OFS = 1;

  function automatic int lane_w(input int data_width);
    return data_width + FLAG_W;
  endfunction

  function automatic int sor_bit(input int data_width);
    return data_width + SOR_OFS;
  endfunction

  function automatic int eor_bit(input int data_width);
    return data_width + EOR_OFS;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/if_row_packer_tagger.sv
// Column/row position tracker: produces start-of-row, end-of-row and
// last-element-of-frame flags for the element currently offered upstream.
module if_row_tagger #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 step,
  input  logic [LEN_WIDTH-1:0] row_len,
  input  logic [LEN_WIDTH-1:0] num_rows,
  output logic                 sor,
  output logic                 eor,
  output logic                 last
);

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  logic [LEN_WIDTH-1:0] col_q, col_d;
  logic [LEN_WIDTH-1:0] row_q, row_d;

  always_comb begin
    sor   = (col_q == '0);
    eor   = (col_q == row_len - ONE);
    last  = eor && (row_q == num_rows - ONE);
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (step) begin
      if (eor) begin
        col_d = '0;
        row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/if_row_packer.sv
// Tags a raw feature-map element stream with row delimiters and packs
// PAR_WRITE tagged elements into each IF-buffer write word.
module if_row_packer
  import if_row_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PAR_WRITE  = 2,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  cfg_start,
  input  logic [LEN_WIDTH-1:0]                  row_len,
  input  logic [LEN_WIDTH-1:0]                  num_rows,
  input  logic                                  s_valid,
  input  logic [DATA_WIDTH-1:0]                 s_data,
  output logic                                  s_ready,
  input  logic                                  fifo_full,
  output logic                                  fifo_wen,
  output logic [PAR_WRITE*(DATA_WIDTH+2)-1:0]   fifo_din,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  cfg_err
);

  localparam int LANE_W  = lane_w(DATA_WIDTH);
  localparam int SOR_B   = sor_bit(DATA_WIDTH);
  localparam int EOR_B   = eor_bit(DATA_WIDTH);
  localparam int LANE_CW = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;
  localparam logic [LANE_CW-1:0] LANE_LAST = LANE_CW'(PAR_WRITE - 1);

  // Handshakes: an element transfers on a rising edge where s_valid & s_ready;
  // a word is written on a rising edge where fifo_wen is high (never while full).

  state_e                              state_q, state_d;
  logic [LEN_WIDTH-1:0]                row_len_q, row_len_d;
  logic [LEN_WIDTH-1:0]                num_rows_q, num_rows_d;
  logic [LANE_CW-1:0]                  lane_cnt_q, lane_cnt_d;
  logic [PAR_WRITE-1:0][LANE_W-1:0]    stage_q, stage_d;
  logic [PAR_WRITE-1:0][LANE_W-1:0]    pend_word_q, pend_word_d;
  logic                                pend_q, pend_d;
  logic                                cfg_err_q, cfg_err_d;

  logic              accept;
  logic              cfg_legal;
  logic              tag_clear;
  logic              tag_sor, tag_eor, tag_last;
  logic [LANE_W-1:0] lane_val;

  if_row_tagger #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_tagger (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (tag_clear),
    .step     (accept),
    .row_len  (row_len_q),
    .num_rows (num_rows_q),
    .sor      (tag_sor),
    .eor      (tag_eor),
    .last     (tag_last)
  );

  // A row length that is not a multiple of PAR_WRITE would split a row across
  // a word boundary with a partial word at frame end, so it is rejected.
  assign cfg_legal = (row_len != '0) && (num_rows != '0) &&
                     ((int'(row_len) % PAR_WRITE) == 0);

  assign s_ready  = (state_q == ST_STREAM) && (!pend_q || !fifo_full);
  assign accept   = s_valid && s_ready;
  assign fifo_wen = pend_q && !fifo_full;
  assign fifo_din = pend_word_q;
  assign busy     = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign cfg_err  = cfg_err_q;

  always_comb begin
    lane_val                   = '0;
    lane_val[SOR_B]            = tag_sor;
    lane_val[EOR_B]            = tag_eor;
    lane_val[DATA_WIDTH-1:0]   = s_data;
  end

  always_comb begin
    state_d     = state_q;
    row_len_d   = row_len_q;
    num_rows_d  = num_rows_q;
    lane_cnt_d  = lane_cnt_q;
    stage_d     = stage_q;
    pend_word_d = pend_word_q;
    pend_d      = pend_q;
    cfg_err_d   = cfg_err_q;
    tag_clear   = 1'b0;

    if (fifo_wen) begin
      pend_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_legal) begin
            row_len_d  = row_len;
            num_rows_d = num_rows;
            lane_cnt_d = '0;
            tag_clear  = 1'b1;
            cfg_err_d  = 1'b0;
            state_d    = ST_STREAM;
          end else begin
            cfg_err_d  = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (accept) begin
          stage_d[lane_cnt_q] = lane_val;
          if (lane_cnt_q == LANE_LAST) begin
            // Completed word moves to the pending register in the same edge
            // that a previous pending word may be leaving it.
            lane_cnt_d  = '0;
            pend_d      = 1'b1;
            pend_word_d = stage_d;
          end else begin
            lane_cnt_d  = lane_cnt_q + LANE_CW'(1);
          end
          if (tag_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!pend_q || fifo_wen) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      row_len_q   <= '0;
      num_rows_q  <= '0;
      lane_cnt_q  <= '0;
      stage_q     <= '0;
      pend_word_q <= '0;
      pend_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_len_q   <= row_len_d;
      num_rows_q  <= num_rows_d;
      lane_cnt_q  <= lane_cnt_d;
      stage_q     <= stage_d;
      pend_word_q <= pend_word_d;
      pend_q      <= pend_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_if_row_packer.sv
// Directed-plus-random bench for if_row_packer (PAR_WRITE=2 and PAR_WRITE=1
// instances) checked against a frame-level reference model.
module tb_if_row_packer;
  import if_row_packer_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        cfg_a, sv_a, sr_a, full_a, wen_a, busy_a, done_a, err_a;
  logic [7:0]  rl_a, nr_a;
  logic [15:0] sd_a;
  logic [35:0] din_a;

  logic        cfg_b, sv_b, sr_b, full_b, wen_b, busy_b, done_b, err_b;
  logic [7:0]  rl_b, nr_b;
  logic [15:0] sd_b;
  logic [17:0] din_b;

  if_row_packer #(.DATA_WIDTH(16), .PAR_WRITE(2), .LEN_WIDTH(8)) dut_a (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_a), .row_len(rl_a), .num_rows(nr_a),
    .s_valid(sv_a), .s_data(sd_a), .s_ready(sr_a), .fifo_full(full_a),
    .fifo_wen(wen_a), .fifo_din(din_a), .busy(busy_a), .done(done_a), .cfg_err(err_a)
  );

  if_row_packer #(.DATA_WIDTH(16), .PAR_WRITE(1), .LEN_WIDTH(8)) dut_b (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_b), .row_len(rl_b), .num_rows(nr_b),
    .s_valid(sv_b), .s_data(sd_b), .s_ready(sr_b), .fifo_full(full_b),
    .fifo_wen(wen_b), .fifo_din(din_b), .busy(busy_b), .done(done_b), .cfg_err(err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  logic [15:0] data_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: element i sits at column i % rl; words hold par consecutive
  // elements, earliest in lane 0.
  task automatic model_words(input int rl, input int par);
    logic [35:0] w;
    logic [17:0] lane;
    int col;
    w = '0;
    for (int i = 0; i < data_q.size(); i++) begin
      col  = i % rl;
      lane = {(col == 0), (col == rl - 1), data_q[i]};
      w[(i % par) * 18 +: 18] = lane;
      if ((i % par) == par - 1) begin
        exp_q.push_back(w);
        w = '0;
      end
    end
  endtask

  task automatic run_a(input int rl, input int nr, input int full_lo, input int full_hi,
                       input bit seq, input bit gaps, input int done_at);
    int total, nwords, sent, done_c;
    bit finished;
    total  = rl * nr;
    nwords = total / 2;
    data_q.delete(); exp_q.delete(); got_q.delete();
    for (int i = 0; i < total; i++) data_q.push_back(seq ? 16'(i + 1) : 16'($urandom));
    model_words(rl, 2);
    @(negedge clk);
    cfg_a = 1'b1; rl_a = 8'(rl); nr_a = 8'(nr); sv_a = 1'b0; full_a = 1'b0;
    sent = 0; finished = 1'b0; done_c = -1;
    for (int c = 0; c < 3000 && !finished; c++) begin
      int words_done, written;
      bit pend, e_ready;
      @(negedge clk);
      cfg_a  = 1'b0;
      full_a = (c >= full_lo) && (c <= full_hi);
      sv_a   = (sent < total) && (!gaps || $urandom_range(0, 3) != 0);
      sd_a   = (sent < total) ? data_q[sent] : 16'($urandom);
      #1;
      words_done = sent / 2;
      written    = got_q.size();
      pend       = words_done > written;
      e_ready    = (sent < total) && !(pend && full_a);
      chk("s_ready", sr_a, e_ready);
      chk("fifo_wen", wen_a, pend && !full_a);
      chk("busy", busy_a, written < nwords);
      chk("done", done_a, written == nwords);
      chk("cfg_err", err_a, 1'b0);
      if (wen_a) got_q.push_back(din_a);
      if (sv_a && e_ready) sent++;
      if (written == nwords) begin
        finished = 1'b1;
        done_c   = c;
      end
    end
    chk("frame_finished", finished, 1'b1);
    chk("word_count", got_q.size(), nwords);
    for (int i = 0; i < nwords && i < got_q.size(); i++) chk("word", got_q[i], exp_q[i]);
    if (done_at >= 0) chk("done_cycle", done_c, done_at);
    @(negedge clk);
    sv_a = 1'b0; full_a = 1'b0;
    #1;
    chk("busy_after", busy_a, 1'b0);
    chk("done_after", done_a, 1'b0);
  endtask

  task automatic run_b(input int rl, input int nr);
    int total, sent;
    bit finished;
    total = rl * nr;
    data_q.delete(); exp_q.delete(); got_q.delete();
    for (int i = 0; i < total; i++) data_q.push_back(16'($urandom));
    model_words(rl, 1);
    @(negedge clk);
    cfg_b = 1'b1; rl_b = 8'(rl); nr_b = 8'(nr); sv_b = 1'b0; full_b = 1'b0;
    sent = 0; finished = 1'b0;
    for (int c = 0; c < 500 && !finished; c++) begin
      int written;
      @(negedge clk);
      cfg_b = 1'b0;
      sv_b  = (sent < total);
      sd_b  = (sent < total) ? data_q[sent] : 16'($urandom);
      #1;
      written = got_q.size();
      chk("b_s_ready", sr_b, sent < total);
      chk("b_fifo_wen", wen_b, sent > written);
      chk("b_done", done_b, written == total);
      if (wen_b) got_q.push_back({18'd0, din_b});
      if (sv_b && sr_b) sent++;
      if (written == total) finished = 1'b1;
    end
    chk("b_finished", finished, 1'b1);
    chk("b_word_count", got_q.size(), total);
    for (int i = 0; i < total && i < got_q.size(); i++) begin
      chk("b_word", got_q[i], exp_q[i]);
      chk("b_flags", got_q[i][17:16], 2'b11);
    end
    @(negedge clk);
    sv_b = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    cfg_a = 0; rl_a = 0; nr_a = 0; sv_a = 0; sd_a = 0; full_a = 0;
    cfg_b = 0; rl_b = 0; nr_b = 0; sv_b = 0; sd_b = 0; full_b = 0;
    #12;
    chk("rst_s_ready", sr_a, 1'b0);
    chk("rst_wen", wen_a, 1'b0);
    chk("rst_din", din_a, 36'd0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_b_wen", wen_b, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic frame, data 1..8, no back-pressure.
    run_a(4, 2, -1, -1, 1'b1, 1'b0, 9);
    chk("t1_word0", got_q[0], {18'h00002, 18'h20001});
    chk("t1_word1", got_q[1], {18'h10004, 18'h00003});
    chk("t1_word3", got_q[3], {18'h10008, 18'h00007});

    // Same frame with the FIFO full for cycles 3..10.
    run_a(4, 2, 3, 10, 1'b1, 1'b0, -1);

    // Illegal configurations, then a legal one clears the flag.
    @(negedge clk);
    cfg_a = 1'b1; rl_a = 8'd3; nr_a = 8'd2; sv_a = 1'b1;
    @(negedge clk);
    cfg_a = 1'b0;
    #1;
    chk("ill_err", err_a, 1'b1);
    chk("ill_busy", busy_a, 1'b0);
    chk("ill_ready", sr_a, 1'b0);
    chk("ill_state", dut_a.state_q, ST_IDLE);
    @(negedge clk);
    cfg_a = 1'b1; rl_a = 8'd0; nr_a = 8'd1;
    @(negedge clk);
    cfg_a = 1'b0; sv_a = 1'b0;
    #1;
    chk("ill_zero_err", err_a, 1'b1);
    chk("ill_zero_busy", busy_a, 1'b0);
    run_a(2, 2, -1, -1, 1'b0, 1'b0, -1);

    // One element per word, every element is a whole row.
    run_b(1, 3);

    // Reset asserted mid-frame after three accepted elements.
    @(negedge clk);
    cfg_a = 1'b1; rl_a = 8'd4; nr_a = 8'd2; sv_a = 1'b0; full_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cfg_a = 1'b0; sv_a = 1'b1; sd_a = 16'($urandom);
    end
    @(posedge clk);
    #3;
    rstn = 1'b0; sv_a = 1'b0;
    #1;
    chk("abort_state", dut_a.state_q, ST_IDLE);
    chk("abort_ready", sr_a, 1'b0);
    chk("abort_wen", wen_a, 1'b0);
    chk("abort_din", din_a, 36'd0);
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_done", done_a, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    run_a(4, 1, -1, -1, 1'b0, 1'b0, 5);
    chk("abort_first_sor", got_q[0][17], 1'b1);

    // Sustained throughput: 32 back-to-back accepts.
    run_a(8, 4, -1, -1, 1'b0, 1'b0, 33);

    // Random legal frames with random gaps and full windows.
    for (int it = 0; it < 4; it++) begin
      int lo;
      lo = $urandom_range(0, 10);
      run_a(2 * $urandom_range(1, 6), $urandom_range(1, 4), lo, lo + $urandom_range(0, 15),
            1'b0, 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
